// File: rtl/vga_pkg.sv
// Shared definitions for the command path into inputDecode.
// Contents: idle code, the 4-bit command codes, and the scheduler FSM state type.
package vga_pkg;

    // Code the decoder ignores; driven whenever no command is being issued.
    localparam logic [3:0] IDLE_CODE  = 4'hF;

    localparam logic [3:0] CMD_NUM0   = 4'h0;
    localparam logic [3:0] CMD_NUM1   = 4'h1;
    localparam logic [3:0] CMD_NUM2   = 4'h2;
    localparam logic [3:0] CMD_NUM3   = 4'h3;
    localparam logic [3:0] CMD_R      = 4'h4;
    localparam logic [3:0] CMD_G      = 4'h5;
    localparam logic [3:0] CMD_B      = 4'h6;
    localparam logic [3:0] CMD_UP     = 4'h7;
    localparam logic [3:0] CMD_DOWN   = 4'h8;
    localparam logic [3:0] CMD_LEFT   = 4'h9;
    localparam logic [3:0] CMD_RIGHT  = 4'hA;
    localparam logic [3:0] CMD_GROW   = 4'hB;
    localparam logic [3:0] CMD_SHRINK = 4'hC;
    localparam logic [3:0] CMD_BKGRD  = 4'hD;
    localparam logic [3:0] CMD_FLASH  = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/demo_rom.sv
// Fixed demo script used by the scheduler's internal sequencer.
// Ports:
//   step - script index, 0..7
//   code - command code for that step
module demo_rom
    import vga_pkg::*;
(
    input  logic [2:0] step,
    output logic [3:0] code
);

    always_comb begin
        code = IDLE_CODE;
        unique case (step)
            3'd0: code = CMD_R;
            3'd1: code = CMD_UP;
            3'd2: code = CMD_GROW;
            3'd3: code = CMD_G;
            3'd4: code = CMD_DOWN;
            3'd5: code = CMD_SHRINK;
            3'd6: code = CMD_B;
            3'd7: code = CMD_FLASH;
            default: code = IDLE_CODE;
        endcase
    end

endmodule

// File: rtl/cmd_scheduler.sv
// Command scheduler in front of inputDecode. Arbitrates keyboard commands
// (buffered in a small FIFO, priority) against a periodic demo sequencer and
// issues each command as a one-cycle pulse on inCode followed by an idle gap.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   keyValid, keyCode     - keyboard strobe and code (source cannot stall)
//   keyReady              - FIFO not full
//   demoEn                - enables the demo sequencer
//   inCode, cmdIssued     - registered command bus and its one-cycle qualifier
//   busy                  - FSM not idle or FIFO non-empty
//   overflow              - sticky: a key was dropped because the FIFO was full
module cmd_scheduler
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int DEMO_PERIOD = 1000,
    parameter int DEMO_LEN    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       keyValid,
    input  logic [3:0] keyCode,
    output logic       keyReady,
    input  logic       demoEn,
    output logic [3:0] inCode,
    output logic       cmdIssued,
    output logic       busy,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(DEMO_PERIOD);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TW-1:0] TIMER_LOAD = TW'(DEMO_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]    STEP_LAST  = 3'(DEMO_LEN - 1);

    sched_state_e  state_q, state_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [3:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    step_q, step_d;
    logic          pending_q, pending_d;
    logic [3:0]    in_code_q, in_code_d;
    logic          cmd_issued_q, cmd_issued_d;
    logic          overflow_q, overflow_d;

    logic       full, empty, key_is_cmd, push, drop, pop;
    logic [3:0] rom_code;

    demo_rom u_demo_rom (
        .step (step_q),
        .code (rom_code)
    );

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Fullness is judged before any same-cycle pop.
    assign key_is_cmd = (keyCode != IDLE_CODE);
    assign push       = keyValid && !full && key_is_cmd;
    assign drop       = keyValid &&  full && key_is_cmd;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = keyCode;
    end

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        step_d       = step_q;
        pending_d    = pending_q;
        timer_d      = timer_q;
        in_code_d    = IDLE_CODE;
        cmd_issued_d = 1'b0;
        pop          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    in_code_d    = mem_q[rd_ptr_q[AW-1:0]];
                    cmd_issued_d = 1'b1;
                    state_d      = ST_ISSUE;
                end else if (pending_q) begin
                    in_code_d    = rom_code;
                    cmd_issued_d = 1'b1;
                    pending_d    = 1'b0;
                    step_d       = (step_q == STEP_LAST) ? 3'd0 : step_q + 3'd1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (GAP_CYCLES > 0) begin
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // A timer expiry coinciding with a demo issue raises a fresh request.
        if (!demoEn) begin
            timer_d   = TIMER_LOAD;
            pending_d = 1'b0;
        end else if (timer_q == '0) begin
            timer_d   = TIMER_LOAD;
            pending_d = 1'b1;
        end else begin
            timer_d   = timer_q - TW'(1);
        end
    end

    assign wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    assign rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    assign overflow_d = overflow_q | drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            gap_q        <= '0;
            timer_q      <= TIMER_LOAD;
            step_q       <= 3'd0;
            pending_q    <= 1'b0;
            in_code_q    <= IDLE_CODE;
            cmd_issued_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            gap_q        <= gap_d;
            timer_q      <= timer_d;
            step_q       <= step_d;
            pending_q    <= pending_d;
            in_code_q    <= in_code_d;
            cmd_issued_q <= cmd_issued_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign keyReady  = !full;
    assign busy      = (state_q != ST_IDLE) || !empty;
    assign inCode    = in_code_q;
    assign cmdIssued = cmd_issued_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
module tb_cmd_scheduler;

    localparam int DEPTH  = 4;
    localparam int GAP    = 2;
    localparam int PERIOD = 10;
    localparam int LEN    = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       keyValid = 1'b0;
    logic [3:0] keyCode = 4'h0;
    logic       demoEn = 1'b0;
    logic       keyReady, cmdIssued, busy, overflow;
    logic [3:0] inCode;

    cmd_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP),
        .DEMO_PERIOD(PERIOD),
        .DEMO_LEN   (LEN)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .keyValid (keyValid),
        .keyCode  (keyCode),
        .keyReady (keyReady),
        .demoEn   (demoEn),
        .inCode   (inCode),
        .cmdIssued(cmdIssued),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] code;
        int         edge_n;
    } exp_t;

    exp_t       expq[$];
    logic [3:0] seen[$];

    // Reference model: FIFO as a queue, pulse spacing as a cooldown count of
    // edges on which nothing may be issued.
    logic [3:0] mq[$];
    int         m_cool = 0;
    int         m_timer = PERIOD - 1;
    int         m_step = 0;
    bit         m_pending = 0;
    bit         m_ovf = 0;
    int         edge_cnt = 0;

    function automatic logic [3:0] script(input int s);
        case (s)
            0: return 4'h4;
            1: return 4'h7;
            2: return 4'hB;
            3: return 4'h5;
            4: return 4'h8;
            5: return 4'hC;
            6: return 4'h6;
            default: return 4'hE;
        endcase
    endfunction

    always @(posedge clock) begin : model
        bit   was_full;
        exp_t e;
        edge_cnt++;
        if (reset) begin
            mq.delete();
            expq.delete();
            m_cool    = 0;
            m_timer   = PERIOD - 1;
            m_step    = 0;
            m_pending = 0;
            m_ovf     = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (m_cool == 0 && mq.size() > 0) begin
                e.code   = mq.pop_front();
                e.edge_n = edge_cnt;
                expq.push_back(e);
                m_cool = GAP + 1;
            end else if (m_cool == 0 && m_pending) begin
                e.code   = script(m_step);
                e.edge_n = edge_cnt;
                expq.push_back(e);
                m_pending = 0;
                m_step    = (m_step + 1) % LEN;
                m_cool    = GAP + 1;
            end else if (m_cool > 0) begin
                m_cool--;
            end
            if (keyValid && keyCode != 4'hF) begin
                if (!was_full) mq.push_back(keyCode);
                else           m_ovf = 1;
            end
            if (!demoEn) begin
                m_timer   = PERIOD - 1;
                m_pending = 0;
            end else if (m_timer == 0) begin
                m_timer   = PERIOD - 1;
                m_pending = 1;
            end else begin
                m_timer--;
            end
        end
    end

    // Monitor: compares every cycle's outputs against the model's queue/state.
    always @(posedge clock) begin : monitor
        exp_t e;
        bit   m_busy;
        #1;
        if (cmdIssued) begin
            seen.push_back(inCode);
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got code %h at edge %0d, required no command", inCode, edge_cnt);
            end else begin
                e = expq.pop_front();
                if (inCode !== e.code || e.edge_n != edge_cnt) begin
                    errors++;
                    $display("FAIL issue: got code %h at edge %0d, required code %h at edge %0d",
                             inCode, edge_cnt, e.code, e.edge_n);
                end
            end
        end else begin
            checks++;
            if (inCode !== 4'hF) begin
                errors++;
                $display("FAIL idle_code: got %h, required F (edge %0d)", inCode, edge_cnt);
            end
            while (expq.size() > 0 && expq[0].edge_n <= edge_cnt) begin
                e = expq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_issue: got none, required code %h at edge %0d", e.code, e.edge_n);
            end
        end
        m_busy = (m_cool > 0) || (mq.size() > 0);
        checks++;
        if (busy !== m_busy || keyReady !== (mq.size() < DEPTH) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL status: got busy=%b keyReady=%b overflow=%b, required %b %b %b (edge %0d)",
                     busy, keyReady, overflow, m_busy, mq.size() < DEPTH, m_ovf, edge_cnt);
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        bit saw_full;
        int drain;

        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        chk("reset_inCode", inCode, 4'hF);
        chk("reset_cmdIssued", cmdIssued, 0);
        chk("reset_busy", busy, 0);
        chk("reset_keyReady", keyReady, 1);
        chk("reset_overflow", overflow, 0);
        cycles(20);

        // Single key.
        seen.delete();
        keyValid = 1'b1; keyCode = 4'hE;
        cycles(1);
        keyValid = 1'b0;
        cycles(8);
        chk("single_count", seen.size(), 1);
        if (seen.size() > 0) chk("single_code", seen[0], 4'hE);

        // Burst of six keys into a four-deep FIFO.
        seen.delete();
        saw_full = 0;
        for (int i = 1; i <= 6; i++) begin
            keyValid = 1'b1; keyCode = 4'(i);
            if (!keyReady) saw_full = 1;
            cycles(1);
        end
        keyValid = 1'b0;
        chk("burst_saw_full", saw_full, 1);
        chk("burst_overflow", overflow, 1);
        cycles(30);
        chk("burst_count", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk("burst_order", seen[i], i + 1);

        // Demo sequencer alone: step wraps after the eighth command.
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        seen.delete();
        demoEn = 1'b1;
        cycles(95);
        demoEn = 1'b0;
        chk("demo_count", seen.size(), 9);
        for (int i = 0; i < 9 && i < seen.size(); i++) chk("demo_code", seen[i], script(i % LEN));

        // Key and demo request both pending: key first, demo follows.
        cycles(2);
        seen.delete();
        demoEn = 1'b1;
        cycles(9);
        keyValid = 1'b1; keyCode = 4'h3;
        cycles(1);
        keyValid = 1'b0;
        cycles(8);
        demoEn = 1'b0;
        chk("collide_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("collide_first", seen[0], 4'h3);
            chk("collide_second", seen[1], script(1));
        end

        // Reset while in the gap with keys still queued.
        cycles(4);
        for (int i = 1; i <= 4; i++) begin
            keyValid = 1'b1; keyCode = 4'(i);
            cycles(1);
        end
        keyValid = 1'b0;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk("gapreset_inCode", inCode, 4'hF);
        chk("gapreset_cmdIssued", cmdIssued, 0);
        chk("gapreset_busy", busy, 0);
        chk("gapreset_keyReady", keyReady, 1);
        seen.delete();
        cycles(20);
        chk("gapreset_no_issue", seen.size(), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            keyValid = ($urandom_range(2) == 0);
            keyCode  = 4'($urandom);
            if ($urandom_range(199) == 0) demoEn = ~demoEn;
            reset = ($urandom_range(499) == 0);
            cycles(1);
        end
        keyValid = 1'b0;
        reset    = 1'b0;
        demoEn   = 1'b0;
        drain = 0;
        while ((expq.size() > 0 || busy) && drain < 100) begin
            cycles(1);
            drain++;
        end
        cycles(2);
        chk("drain_pending", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_scheduler.md
Name: cmd_scheduler

Overview:
- Sits directly upstream of inputDecode and drives its 4-bit inCode bus.
- Arbitrates between two command sources: keyboard commands (buffered in a small FIFO) and an internal demo sequencer that steps through a fixed script.
- Issues every command as a single-cycle pulse followed by an idle gap, because the decoder toggles and steps on every clock a code is held.
- Between and around commands, drives the non-decoded idle code 4'hF.

Parameters:
- FIFO_DEPTH, 4: keyboard command FIFO entries (power of 2, at least 2).
- GAP_CYCLES, 2: idle cycles forced after each issued command (0 allowed).
- DEMO_PERIOD, 1000: clocks between demo command requests (at least 2).
- DEMO_LEN, 8: number of demo script entries used (1..8).

Ports:
- clock, input, 1: system clock; all logic rises on it.
- reset, input, 1: synchronous, active-high reset.
- keyValid, input, 1: keyboard command strobe; the source cannot stall.
- keyCode, input, 4: keyboard command code, sampled when keyValid=1.
- keyReady, output, 1: FIFO not full.
- demoEn, input, 1: enables the demo sequencer.
- inCode, output, 4: registered command bus to inputDecode.
- cmdIssued, output, 1: high in exactly the cycle inCode carries a command.
- busy, output, 1: FSM not in IDLE, or FIFO non-empty.
- overflow, output, 1: sticky flag for a dropped key; cleared only by reset.

Behaviour:
- Reset (synchronous, wins over everything else):
  - inCode=4'hF, cmdIssued=0, busy=0, overflow=0, keyReady=1.
  - FIFO emptied, FSM=IDLE.
  - Demo timer reloaded to DEMO_PERIOD-1, demo step=0, demoPending=0.
  - Applies mid-ISSUE or mid-GAP with no residual pulse.
- FIFO write:
  - keyValid & keyReady & keyCode!=4'hF: push.
  - keyValid & keyCode==4'hF: discarded silently, no flag.
  - keyValid & !keyReady & keyCode!=4'hF: key dropped, overflow<=1.
  - keyReady = !full. A same-cycle pop does not make room for a push.
- FSM states are IDLE, ISSUE, GAP.
- IDLE:
  - If FIFO non-empty: pop head, inCode<=head, cmdIssued<=1, go to ISSUE.
  - Else if demoPending: inCode<=demo_rom[step], cmdIssued<=1, clear demoPending, step<=(step==DEMO_LEN-1)?0:step+1, go to ISSUE.
  - Else: inCode stays 4'hF.
  - Fixed priority: keyboard over demo. A pending demo command waits; it is never dropped while demoEn=1.
- ISSUE (lasts one cycle):
  - inCode<=4'hF, cmdIssued<=0.
  - GAP_CYCLES>0: load gap counter with GAP_CYCLES-1, go to GAP.
  - GAP_CYCLES==0: go to IDLE.
- GAP:
  - inCode holds 4'hF.
  - Count down; at 0 go to IDLE.
- Command spacing:
  - Minimum spacing between consecutive command pulses is GAP_CYCLES+2 clocks.
  - Exception: GAP_CYCLES==0 gives a spacing of 2.
- Latency:
  - Key accepted at edge N into an empty FIFO with FSM in IDLE: popped at edge N+1.
  - inCode shows the code during cycle N+1..N+2. Total 2 clocks.
- Demo timer:
  - Runs only while demoEn=1. Counts down; at 0 it reloads to DEMO_PERIOD-1 and sets demoPending.
  - Expiry while demoPending is already set does not queue a second request.
  - demoEn=0 holds the timer at DEMO_PERIOD-1 and clears demoPending. Step is held, not reset.
- Widths:
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty use the MSB-compare method.
  - Timer is clog2(DEMO_PERIOD) bits. Step is 3 bits.
- busy is combinational from state and FIFO count.

Decomposition:
- Shared package (vga_pkg):
  - IDLE_CODE=4'hF.
  - Command code constants: CMD_NUM0..3=0..3, CMD_R/G/B=4..6, CMD_UP/DOWN/LEFT/RIGHT=7..A, CMD_GROW=B, CMD_SHRINK=C, CMD_BKGRD=D, CMD_FLASH=E.
  - FSM state enum.
- One sub-module, demo_rom: combinational, 3-bit step in, 4-bit code out.
- Demo script, step 0..7: R, UP, GROW, G, DOWN, SHRINK, B, FLASH.
- The FIFO stays inline.

Test Plan:
- Reset then idle 20 clocks → inCode=F every cycle, cmdIssued=0, busy=0, keyReady=1.
- Single key 4'hE accepted at edge N (GAP_CYCLES=2) → inCode=E for exactly cycle N+1, F for the next 3 cycles, one cmdIssued pulse.
- Burst of 6 keys 1,2,3,4,5,6 on consecutive clocks with FIFO_DEPTH=4:
  - keyReady drops and overflow=1.
  - Issued order is the accepted prefix with no reordering, spaced 4 clocks apart.
  - Exactly the 1 or 2 keys presented while full are missing.
- demoEn=1, DEMO_PERIOD=10, no keys → inCode pulses 4,7,B,5,8,C,6,E,4 at 10-clock intervals (step wraps).
- Demo request and keyboard key pending in the same IDLE cycle → key issued first, demo code follows after the gap. Demo code is not lost.
- Assert reset during GAP with 3 keys queued → next cycle inCode=F, FIFO empty, busy=0. No queued key is issued after reset release.
